attopu_ctrl: RTL and testbench



---
 rtl/attopu_ctrl.sv | 157 +++++++++++++++
 tb/tb_attopu_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/attopu_ctrl.sv
// attopu multi-cycle control unit: fetch over req/ack, IR, sequencing FSM,
// registered zero flag and retired-instruction counter.
module attopu_ctrl #(
   parameter int DATA_W    = 16,
   parameter int REG_SEL_W = 2,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 halt,
   output logic                 imem_req,
   input  logic                 imem_ack,
   input  logic [DATA_W-1:0]    imem_rdata,
   output logic                 dmem_req,
   input  logic                 dmem_ack,
   output logic                 mem_we,
   input  logic                 alu_zero,
   output logic [1:0]           next_pc_sel,
   output logic                 pc_we,
   output logic                 reg_din_src,
   output logic [REG_SEL_W-1:0] reg_wsel,
   output logic [REG_SEL_W-1:0] reg_rsel1,
   output logic [REG_SEL_W-1:0] reg_rsel2,
   output logic                 reg_we,
   output logic [1:0]           alu_op,
   output logic                 d_addr_sel,
   output logic                 st_data_sel,
   output logic [DATA_W-1:0]    addr,
   output logic                 z_flag,
   output logic                 halted,
   output logic [CNT_W-1:0]     retired
);

   localparam int AF_W  = DATA_W-3-REG_SEL_W;
   localparam int EXT_W = DATA_W-AF_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] EXEC  = 2'd2;
   localparam logic [1:0] MEM   = 2'd3;

   localparam logic [1:0] OP_ALU = 2'd0;
   localparam logic [1:0] OP_LD  = 2'd1;
   localparam logic [1:0] OP_ST  = 2'd2;
   localparam logic [1:0] OP_BRZ = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [1:0]        state;
   logic [1:0]        stateNxt;
   logic [DATA_W-1:0] ir;
   logic              zFlag;
   logic [CNT_W-1:0]  retCnt;
   logic              retire;

   logic [1:0]      op;
   logic [AF_W-1:0] af;
   logic            ext;
   logic            isLd;
   logic            isSt;
   logic            memOp;

   assign op    = ir[DATA_W-1 -: 2];
   assign af    = ir[AF_W:1];
   assign ext   = ir[0];
   assign isLd  = (op == OP_LD);
   assign isSt  = (op == OP_ST);
   assign memOp = isLd | isSt;

   assign reg_wsel  = ir[DATA_W-3 -: REG_SEL_W];
   assign reg_rsel1 = ir[DATA_W-3-REG_SEL_W -: REG_SEL_W];
   assign reg_rsel2 = ir[DATA_W-3-2*REG_SEL_W -: REG_SEL_W];
   assign z_flag    = zFlag;
   assign retired   = retCnt;
   assign halted    = (state == IDLE);

   always_comb begin
      stateNxt    = state;
      retire      = 1'b0;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      mem_we      = 1'b0;
      next_pc_sel = 2'b00;
      pc_we       = 1'b0;
      reg_din_src = 1'b0;
      reg_we      = 1'b0;
      alu_op      = 2'b00;
      d_addr_sel  = 1'b0;
      st_data_sel = 1'b0;
      addr        = '0;
      unique case (state)
         IDLE: begin
            if (!halt) stateNxt = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) stateNxt = EXEC;
         end
         EXEC: begin
            unique case (op)
               OP_ALU: begin
                  alu_op = ext ? 2'b10 : 2'b01;
                  reg_we = 1'b1;
                  pc_we  = 1'b1;
                  retire = 1'b1;
               end
               OP_BRZ: begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
                  if (zFlag && ext) begin
                     next_pc_sel = 2'b10;
                  end else if (zFlag) begin
                     next_pc_sel = 2'b01;
                     addr = {{EXT_W{af[AF_W-1]}}, af};
                  end
               end
               default: stateNxt = MEM;
            endcase
         end
         MEM: begin
            dmem_req = 1'b1;
            mem_we   = isSt;
            if (dmem_ack) begin
               pc_we  = 1'b1;
               reg_we = isLd;
               retire = 1'b1;
            end
         end
      endcase
      // LD/ST address and selects stay stable from EXEC through MEM
      if ((state == EXEC || state == MEM) && memOp) begin
         reg_din_src = isLd;
         if (ext) begin
            d_addr_sel = 1'b1;
         end else begin
            addr        = {{EXT_W{1'b0}}, af};
            st_data_sel = isSt;
         end
      end
      if (retire) stateNxt = halt ? IDLE : FETCH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ir     <= '0;
         zFlag  <= 1'b0;
         retCnt <= '0;
      end else begin
         state <= stateNxt;
         if (state == FETCH && imem_ack) ir <= imem_rdata;
         if (state == EXEC && op == OP_ALU) zFlag <= alu_zero;
         if (retire) retCnt <= retCnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_attopu_ctrl.sv
// Randomized bench for attopu_ctrl against an instruction-level model;
// a second instance with a 2-bit counter checks counter wrap.
module tb_attopu_ctrl;

   localparam int DW  = 16;
   localparam int RW  = 2;
   localparam int AFW = DW-3-RW;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic halt = 1'b0;
   logic imem_ack = 1'b0;
   logic dmem_ack = 1'b0;
   logic alu_zero = 1'b0;
   logic [DW-1:0] imem_rdata = '0;

   logic imem_req, dmem_req, mem_we, pc_we, reg_din_src, reg_we;
   logic d_addr_sel, st_data_sel, z_flag, halted;
   logic [1:0] next_pc_sel, alu_op;
   logic [RW-1:0] reg_wsel, reg_rsel1, reg_rsel2;
   logic [DW-1:0] addr;
   logic [15:0] retired;

   logic imemReqS, dmemReqS, memWeS, pcWeS, dinSrcS, regWeS;
   logic dAddrSelS, stSelS, zFlagS, haltedS;
   logic [1:0] npcS, aluOpS;
   logic [RW-1:0] wselS, rsel1S, rsel2S;
   logic [DW-1:0] addrS;
   logic [1:0] retiredS;

   attopu_ctrl dut (
      .clk(clk), .rst_n(rst_n), .halt(halt),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack), .mem_we(mem_we),
      .alu_zero(alu_zero), .next_pc_sel(next_pc_sel), .pc_we(pc_we),
      .reg_din_src(reg_din_src), .reg_wsel(reg_wsel),
      .reg_rsel1(reg_rsel1), .reg_rsel2(reg_rsel2), .reg_we(reg_we),
      .alu_op(alu_op), .d_addr_sel(d_addr_sel), .st_data_sel(st_data_sel),
      .addr(addr), .z_flag(z_flag), .halted(halted), .retired(retired)
   );

   attopu_ctrl #(.CNT_W(2)) dutS (
      .clk(clk), .rst_n(rst_n), .halt(halt),
      .imem_req(imemReqS), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmemReqS), .dmem_ack(dmem_ack), .mem_we(memWeS),
      .alu_zero(alu_zero), .next_pc_sel(npcS), .pc_we(pcWeS),
      .reg_din_src(dinSrcS), .reg_wsel(wselS),
      .reg_rsel1(rsel1S), .reg_rsel2(rsel2S), .reg_we(regWeS),
      .alu_op(aluOpS), .d_addr_sel(dAddrSelS), .st_data_sel(stSelS),
      .addr(addrS), .z_flag(zFlagS), .halted(haltedS), .retired(retiredS)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mCount = 0;
   int mZf = 0;

   logic [10:0] strb;
   assign strb = {imem_req, dmem_req, mem_we, pc_we, reg_we,
                  d_addr_sel, st_data_sel, alu_op, next_pc_sel};

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] mk(input int iq, input int dq,
      input int mw, input int pw, input int rw, input int ds,
      input int ss, input int ao, input int np);
      logic [10:0] v;
      v = {iq[0], dq[0], mw[0], pw[0], rw[0], ds[0], ss[0],
           ao[1:0], np[1:0]};
      return v;
   endfunction

   task automatic doReset();
      rst_n = 1'b0;
      halt = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      mCount = 0;
      mZf = 0;
      @(negedge clk);
      check("rstStrb", strb, 0);
      check("rstDin", reg_din_src, 0);
      check("rstAddr", addr, 0);
      check("rstRsel", {reg_wsel, reg_rsel1, reg_rsel2}, 0);
      check("rstHalted", halted, 1);
      check("rstRetired", retired, 0);
      check("rstZ", z_flag, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("postRstIdle", {halted, imem_req}, 2'b10);
      @(posedge clk); #1;
   endtask

   task automatic runInstr(input logic [15:0] ins, input int iw,
                           input int dw, input int az, input int hv,
                           input int abortMem);
      int i, op, rd, rs1, rs2, ext, af, afSx, ld, dsel, ssel, eAddr;
      int npc, ack;
      i    = int'(ins);
      op   = (i >> 14) & 3;
      rd   = (i >> 12) & 3;
      rs1  = (i >> 10) & 3;
      rs2  = (i >> 8) & 3;
      ext  = i & 1;
      af   = (i >> 1) & ((1 << AFW) - 1);
      afSx = (af >= (1 << (AFW-1))) ? af + 65536 - (1 << AFW) : af;
      for (int w = 0; w <= iw; w++) begin
         halt = 1'($urandom % 2);
         imem_ack = (w == iw);
         imem_rdata = imem_ack ? ins : DW'($urandom);
         @(negedge clk);
         check("fetchStrb", strb, mk(1,0,0,0,0,0,0,0,0));
         check("fetchHalted", halted, 0);
         if (w == 0) begin
            check("retired", retired, mCount % 65536);
            check("retiredWrap", retiredS, mCount % 4);
            check("zFlag", z_flag, mZf);
         end
         @(posedge clk); #1;
      end
      imem_ack = 1'b0;
      imem_rdata = DW'($urandom);
      halt = hv[0];
      alu_zero = az[0];
      @(negedge clk);
      check("rsel", {reg_wsel, reg_rsel1, reg_rsel2},
            rd * 16 + rs1 * 4 + rs2);
      ld = (op == 1);
      dsel = ext;
      ssel = (!ext && op == 2);
      eAddr = ext ? 0 : af;
      if (op == 0) begin
         check("aluStrb", strb, mk(0,0,0,1,1,0,0,ext ? 2 : 1,0));
         check("aluAddr", addr, 0);
         check("aluDin", reg_din_src, 0);
         mZf = az;
         mCount++;
      end else if (op == 3) begin
         npc = mZf ? (ext ? 2 : 1) : 0;
         check("brzStrb", strb, mk(0,0,0,1,0,0,0,0,npc));
         check("brzAddr", addr, (mZf && !ext) ? afSx : 0);
         check("brzZ", z_flag, mZf);
         mCount++;
      end else begin
         check("execStrb", strb, mk(0,0,0,0,0,dsel,ssel,0,0));
         check("execAddr", addr, eAddr);
         if (!ld) check("execDin", reg_din_src, 0);
      end
      @(posedge clk); #1;
      if (op == 1 || op == 2) begin
         for (int w = 0; w <= dw; w++) begin
            if (abortMem != 0) begin
               #2;
               rst_n = 1'b0;
               #1;
               check("abortStrb", strb, 0);
               check("abortAddr", addr, 0);
               check("abortHalted", halted, 1);
               check("abortRetired", retired, 0);
               check("abortRetiredWrap", retiredS, 0);
               return;
            end
            ack = (w == dw);
            dmem_ack = ack[0];
            @(negedge clk);
            check("memStrb", strb,
                  mk(0,1,!ld,ack,ld && ack,dsel,ssel,0,0));
            check("memAddr", addr, eAddr);
            if (ld && ack) check("ldDin", reg_din_src, 1);
            if (!ld) check("stDin", reg_din_src, 0);
            @(posedge clk); #1;
         end
         dmem_ack = 1'b0;
         mCount++;
      end
      if (hv != 0) begin
         for (int k = 0; k <= int'($urandom % 3); k++) begin
            @(negedge clk);
            check("haltIdle", {halted, strb}, {1'b1, 11'd0});
            @(posedge clk); #1;
         end
         halt = 1'b0;
         @(negedge clk);
         check("releaseIdle", {halted, imem_req}, 2'b10);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2;
      doReset();
      runInstr(16'h1B00, 0, 0, 1, 0, 0);
      runInstr(16'h600A, 0, 3, 0, 0, 0);
      runInstr(16'h8001, 1, 2, 0, 0, 0);
      runInstr(16'hCFFC, 0, 0, 0, 0, 0);
      runInstr(16'h1B00, 2, 0, 0, 0, 0);
      runInstr(16'hCFFC, 0, 0, 0, 0, 0);
      runInstr(16'h1B01, 0, 0, 1, 0, 0);
      runInstr(16'hC001, 1, 0, 0, 0, 0);
      runInstr(16'h600A, 0, 2, 0, 1, 0);
      runInstr(16'h600A, 0, 3, 0, 0, 1);
      doReset();
      for (int n = 0; n < 5; n++)
         runInstr(16'h1B00, n % 2, 0, n % 2, 0, 0);
      @(negedge clk);
      check("fiveAdds", retiredS, 1);
      @(posedge clk); #1;
      for (int n = 0; n < 300; n++)
         runInstr(16'($urandom), $urandom % 3, $urandom % 4,
                  $urandom % 2, ($urandom % 6) == 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
